coh_cache_ctrl: RTL and testbench

Snooping MSI coherence controller for a direct-mapped cache of NUM_LINES lines. It replaces the single-line CPU-side coherence state machine. It holds a per-line state and tag, serves CPU read/write requests through a valid/ready handshake, arbitrates for the shared bus with a req/gnt handshake, and applies snooped bus traffic to any line. It sits between the CPU port and the shared coherence bus, next to the data array.

---
 rtl/coh_pkg.sv | 51 +++++
 rtl/coh_line_array.sv | 47 ++++
 rtl/coh_cache_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_coh_cache_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coh_pkg.sv
// Shared types for the snooping MSI/MESI coherence controller:
// line-state encodings, bus and snoop command encodings, controller FSM
// states, and the snoop state-transition rule.
// Optional feature macro: COH_EXCLUSIVE_EN (adds the E state).
package coh_pkg;

    typedef enum logic [1:0] {
        LS_I = 2'b00,
        LS_S = 2'b01,
        LS_M = 2'b10,
        LS_E = 2'b11
    } line_state_t;

    typedef enum logic [2:0] {
        CMD_NONE       = 3'd0,
        CMD_READ_MISS  = 3'd1,
        CMD_WRITE_MISS = 3'd2,
        CMD_INVALIDATE = 3'd3,
        CMD_WRITE_BACK = 3'd4
    } bus_cmd_t;

    localparam logic [1:0] SNP_READ_MISS  = 2'd1;
    localparam logic [1:0] SNP_WRITE_MISS = 2'd2;
    localparam logic [1:0] SNP_INVALIDATE = 2'd3;

    typedef enum logic [2:0] {
        FSM_IDLE,
        FSM_LOOKUP,
        FSM_WB_REQ,
        FSM_MISS_REQ,
        FSM_DONE
    } fsm_state_t;

    // New state of a valid, tag-matching line after a foreign bus command.
    // E only ever exists when the exclusive feature is built in, so the
    // E arms are harmless in a pure MSI build.
    function automatic line_state_t snoop_next_state(input line_state_t cur,
                                                     input logic [1:0]  cmd);
        line_state_t nxt;
        nxt = cur;
        case (cmd)
            SNP_READ_MISS: begin
                if (cur == LS_M || cur == LS_E) nxt = LS_S;
            end
            SNP_WRITE_MISS, SNP_INVALIDATE: nxt = LS_I;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/coh_line_array.sv
// Tag + coherence-state storage for the direct-mapped cache.
// Two combinational read ports (CPU side, snoop side) and one write port;
// the controller decides which requester owns the write port each cycle.
module coh_line_array
    import coh_pkg::*;
#(
    parameter int IDX_W = 3,
    parameter int TAG_W = 13
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [IDX_W-1:0] cpu_idx,
    output logic [TAG_W-1:0] cpu_tag,
    output line_state_t      cpu_st,
    input  logic [IDX_W-1:0] snp_idx,
    output logic [TAG_W-1:0] snp_tag,
    output line_state_t      snp_st,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  line_state_t      wr_st
);

    localparam int NUM_LINES = 1 << IDX_W;

    logic [TAG_W-1:0] tag_mem [NUM_LINES];
    line_state_t      st_mem  [NUM_LINES];

    // Single write port; reset invalidates every line and clears its tag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                tag_mem[i] <= '0;
                st_mem[i]  <= LS_I;
            end
        end else if (wr_en) begin
            tag_mem[wr_idx] <= wr_tag;
            st_mem[wr_idx]  <= wr_st;
        end
    end

    assign cpu_tag = tag_mem[cpu_idx];
    assign cpu_st  = st_mem[cpu_idx];
    assign snp_tag = tag_mem[snp_idx];
    assign snp_st  = st_mem[snp_idx];

endmodule

// File: rtl/coh_cache_ctrl.sv
// Snooping coherence controller for a direct-mapped cache.
// Serves CPU requests, arbitrates for the shared bus, and applies snooped
// traffic to any line in any FSM state. Snoop updates take priority on the
// single write port of the line array; the bus never grants and snoops in
// the same cycle, so only the silent E->M upgrade can collide with a snoop.
// Optional feature macro: COH_EXCLUSIVE_EN (MESI; default build is MSI).
module coh_cache_ctrl
    import coh_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int IDX_W  = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cpu_valid,
    output logic              cpu_ready,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_done,
    output logic              cpu_hit,
    output logic [1:0]        cpu_state,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic [2:0]        bus_cmd,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_shared,
    input  logic              snoop_valid,
    input  logic [1:0]        snoop_cmd,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              snoop_wb
);

    localparam int TAG_W = ADDR_W - IDX_W;

    fsm_state_t        state, state_nxt;
    logic [ADDR_W-1:0] req_addr;
    logic              req_write;
    bus_cmd_t          pend_cmd;
    logic              hit_r;
    line_state_t       done_st;

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [TAG_W-1:0]  cpu_tag;
    line_state_t       cpu_st;

    logic [IDX_W-1:0]  snp_idx;
    logic [TAG_W-1:0]  snp_tag_in;
    logic [TAG_W-1:0]  snp_tag;
    line_state_t       snp_st;
    logic              snoop_hit;
    line_state_t       snoop_st_nxt;

    line_state_t       eff_st;
    logic              lookup_hit;
    line_state_t       rd_grant_st;

    logic              fsm_wr_en;
    logic [TAG_W-1:0]  fsm_wr_tag;
    line_state_t       fsm_wr_st;
    logic              cmd_ld;
    bus_cmd_t          cmd_nxt;
    logic              done_ld;
    logic              done_hit_nxt;
    line_state_t       done_st_nxt;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [TAG_W-1:0]  wr_tag;
    line_state_t       wr_st;

    assign req_idx    = req_addr[IDX_W-1:0];
    assign req_tag    = req_addr[ADDR_W-1:IDX_W];
    assign snp_idx    = snoop_addr[IDX_W-1:0];
    assign snp_tag_in = snoop_addr[ADDR_W-1:IDX_W];

    coh_line_array #(
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_lines (
        .clock   (clock),
        .reset_n (reset_n),
        .cpu_idx (req_idx),
        .cpu_tag (cpu_tag),
        .cpu_st  (cpu_st),
        .snp_idx (snp_idx),
        .snp_tag (snp_tag),
        .snp_st  (snp_st),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_tag  (wr_tag),
        .wr_st   (wr_st)
    );

    // Snoop side: only a valid line with a matching tag reacts.
    assign snoop_hit    = snoop_valid && (snoop_cmd != 2'd0) &&
                          (snp_st != LS_I) && (snp_tag == snp_tag_in);
    assign snoop_st_nxt = snoop_next_state(snp_st, snoop_cmd);
    assign snoop_wb     = snoop_hit && (snp_st == LS_M);

    // The CPU-side view of the indexed line with this cycle's snoop already
    // applied, so LOOKUP and the pending-request checks never act on stale state.
    assign eff_st     = (snoop_hit && (snp_idx == req_idx)) ? snoop_st_nxt : cpu_st;
    assign lookup_hit = (eff_st != LS_I) && (cpu_tag == req_tag);

`ifdef COH_EXCLUSIVE_EN
    assign rd_grant_st = bus_shared ? LS_S : LS_E;
`else
    logic unused_shared;
    assign rd_grant_st   = LS_S;
    assign unused_shared = bus_shared;
`endif

    // Write-port arbitration: a snoop update wins over any controller write.
    assign wr_en  = snoop_hit || fsm_wr_en;
    assign wr_idx = snoop_hit ? snp_idx      : req_idx;
    assign wr_tag = snoop_hit ? snp_tag      : fsm_wr_tag;
    assign wr_st  = snoop_hit ? snoop_st_nxt : fsm_wr_st;

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= FSM_IDLE;
        else          state <= state_nxt;
    end

    // Request capture, pending bus command and completion status.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            req_addr  <= '0;
            req_write <= 1'b0;
            pend_cmd  <= CMD_NONE;
            hit_r     <= 1'b0;
            done_st   <= LS_I;
        end else begin
            if (state == FSM_IDLE && cpu_valid) begin
                req_addr  <= cpu_addr;
                req_write <= cpu_write;
            end
            if (cmd_ld) pend_cmd <= cmd_nxt;
            if (done_ld) begin
                hit_r   <= done_hit_nxt;
                done_st <= done_st_nxt;
            end
        end
    end

    // Next-state, line-array writes and bookkeeping for the controller.
    always_comb begin
        state_nxt    = state;
        fsm_wr_en    = 1'b0;
        fsm_wr_tag   = req_tag;
        fsm_wr_st    = LS_I;
        cmd_ld       = 1'b0;
        cmd_nxt      = pend_cmd;
        done_ld      = 1'b0;
        done_hit_nxt = 1'b0;
        done_st_nxt  = LS_I;
        case (state)
            FSM_IDLE: begin
                if (cpu_valid) state_nxt = FSM_LOOKUP;
            end
            FSM_LOOKUP: begin
                if (lookup_hit) begin
                    if (!req_write || eff_st == LS_M) begin
                        state_nxt    = FSM_DONE;
                        done_ld      = 1'b1;
                        done_hit_nxt = 1'b1;
                        done_st_nxt  = eff_st;
`ifdef COH_EXCLUSIVE_EN
                    end else if (eff_st == LS_E) begin
                        // Silent upgrade needs the write port; if a snoop owns
                        // it this cycle, stay in LOOKUP and retry.
                        if (!snoop_hit) begin
                            fsm_wr_en    = 1'b1;
                            fsm_wr_st    = LS_M;
                            state_nxt    = FSM_DONE;
                            done_ld      = 1'b1;
                            done_hit_nxt = 1'b1;
                            done_st_nxt  = LS_M;
                        end
`endif
                    end else begin
                        cmd_ld    = 1'b1;
                        cmd_nxt   = CMD_INVALIDATE;
                        state_nxt = FSM_MISS_REQ;
                    end
                end else begin
                    cmd_ld    = 1'b1;
                    cmd_nxt   = req_write ? CMD_WRITE_MISS : CMD_READ_MISS;
                    state_nxt = (eff_st == LS_M) ? FSM_WB_REQ : FSM_MISS_REQ;
                end
            end
            FSM_WB_REQ: begin
                if (eff_st != LS_M) begin
                    // Victim was snooped away; nothing left to write back.
                    state_nxt = FSM_MISS_REQ;
                end else if (bus_gnt) begin
                    fsm_wr_en  = 1'b1;
                    fsm_wr_tag = cpu_tag;
                    fsm_wr_st  = LS_I;
                    state_nxt  = FSM_MISS_REQ;
                end
            end
            FSM_MISS_REQ: begin
                if (pend_cmd == CMD_INVALIDATE && eff_st == LS_I) begin
                    // Our shared copy is gone; the upgrade becomes a full miss.
                    cmd_ld  = 1'b1;
                    cmd_nxt = CMD_WRITE_MISS;
                end else if (bus_gnt) begin
                    fsm_wr_en    = 1'b1;
                    fsm_wr_st    = (pend_cmd == CMD_READ_MISS) ? rd_grant_st : LS_M;
                    state_nxt    = FSM_DONE;
                    done_ld      = 1'b1;
                    done_hit_nxt = 1'b0;
                    done_st_nxt  = fsm_wr_st;
                end
            end
            FSM_DONE: begin
                state_nxt = FSM_IDLE;
            end
            default: state_nxt = FSM_IDLE;
        endcase
    end

    assign cpu_ready = reset_n && (state == FSM_IDLE);
    assign cpu_done  = (state == FSM_DONE);
    assign cpu_hit   = (state == FSM_DONE) && hit_r;
    assign cpu_state = (state == FSM_DONE) ? done_st : LS_I;

    assign bus_req  = (state == FSM_WB_REQ) || (state == FSM_MISS_REQ);
    assign bus_cmd  = (state == FSM_WB_REQ)   ? CMD_WRITE_BACK :
                      (state == FSM_MISS_REQ) ? pend_cmd       : CMD_NONE;
    assign bus_addr = (state == FSM_WB_REQ)   ? {cpu_tag, req_idx} :
                      (state == FSM_MISS_REQ) ? req_addr           : '0;

endmodule

// File: tb/tb_coh_cache_ctrl.sv
// Self-checking bench for coh_cache_ctrl: directed scenarios followed by
// randomized CPU requests and snoops, checked against a per-line model
// built from the coherence rules. Honours COH_EXCLUSIVE_EN.
module tb_coh_cache_ctrl;

    localparam int NL = 8;
`ifdef COH_EXCLUSIVE_EN
    localparam bit EXCL = 1'b1;
`else
    localparam bit EXCL = 1'b0;
`endif
    localparam logic [2:0] C_NONE = 3'd0, C_RM = 3'd1, C_WM = 3'd2, C_INV = 3'd3, C_WB = 3'd4;
    localparam logic [1:0] S_I = 2'd0, S_S = 2'd1, S_M = 2'd2, S_E = 2'd3;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_valid = 1'b0, cpu_write = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic        cpu_ready, cpu_done, cpu_hit;
    logic [1:0]  cpu_state;
    logic        bus_req;
    logic        bus_gnt = 1'b0, bus_shared = 1'b0;
    logic [2:0]  bus_cmd;
    logic [15:0] bus_addr;
    logic        snoop_valid = 1'b0;
    logic [1:0]  snoop_cmd = '0;
    logic [15:0] snoop_addr = '0;
    logic        snoop_wb;

    int checks = 0;
    int errors = 0;

    logic [12:0] m_tag [NL];
    logic [1:0]  m_st  [NL];

    typedef struct packed {
        logic [2:0]  cmd;
        logic [15:0] addr;
    } txn_t;

    txn_t       plan[$];
    logic [2:0] seen[$];
    logic       last_hit;
    logic [1:0] last_state;

    always #5 clock = ~clock;

    coh_cache_ctrl dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .cpu_valid   (cpu_valid),
        .cpu_ready   (cpu_ready),
        .cpu_write   (cpu_write),
        .cpu_addr    (cpu_addr),
        .cpu_done    (cpu_done),
        .cpu_hit     (cpu_hit),
        .cpu_state   (cpu_state),
        .bus_req     (bus_req),
        .bus_gnt     (bus_gnt),
        .bus_cmd     (bus_cmd),
        .bus_addr    (bus_addr),
        .bus_shared  (bus_shared),
        .snoop_valid (snoop_valid),
        .snoop_cmd   (snoop_cmd),
        .snoop_addr  (snoop_addr),
        .snoop_wb    (snoop_wb)
    );

    // Single shared bus: a grant and a snoop must never coincide.
    always @(posedge clock) begin
        assert (!(snoop_valid && bus_gnt)) else $error("snoop and grant in the same cycle");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            m_tag[i] = '0;
            m_st[i]  = S_I;
        end
    endtask

    // Coherence reaction of a foreign transaction; returns whether data is supplied.
    task automatic model_snoop(input logic [1:0] cmd, input logic [15:0] a, output logic wb);
        logic [2:0] i;
        i  = a[2:0];
        wb = 1'b0;
        if (m_st[i] != S_I && m_tag[i] == a[15:3]) begin
            if (cmd == 2'd1) begin
                if (m_st[i] == S_M) wb = 1'b1;
                if (m_st[i] == S_M || m_st[i] == S_E) m_st[i] = S_S;
            end else if (cmd == 2'd2 || cmd == 2'd3) begin
                wb = (m_st[i] == S_M);
                m_st[i] = S_I;
            end
        end
    endtask

    task automatic snoop_idle(input logic [1:0] cmd, input logic [15:0] a, output logic got_wb);
        logic wb;
        snoop_valid = 1'b1;
        snoop_cmd   = cmd;
        snoop_addr  = a;
        #1;
        got_wb = snoop_wb;
        model_snoop(cmd, a, wb);
        check("snoop_wb_idle", snoop_wb, wb);
        @(posedge clock); #1;
        snoop_valid = 1'b0;
    endtask

    // One CPU request, serving the bus and optionally injecting one snoop
    // while the request is waiting for its grant.
    task automatic run_access(input logic [15:0] a, input logic wr, input logic shared,
                              input logic snp_en, input logic [1:0] snp_cmd,
                              input logic [15:0] snp_addr);
        logic [2:0]  ri;
        logic [12:0] rt;
        logic        exp_hit, done, pend, wb;
        int          lat, lat_g;
        txn_t        t;
        ri = a[2:0];
        rt = a[15:3];
        plan.delete();
        seen.delete();
        if (m_st[ri] != S_I && m_tag[ri] == rt) begin
            if (wr && m_st[ri] == S_S) begin
                t.cmd = C_INV; t.addr = a; plan.push_back(t);
            end else if (wr) begin
                m_st[ri] = S_M;
            end
        end else begin
            if (m_st[ri] == S_M) begin
                t.cmd = C_WB; t.addr = {m_tag[ri], ri}; plan.push_back(t);
            end
            t.cmd = wr ? C_WM : C_RM; t.addr = a; plan.push_back(t);
        end
        exp_hit = (plan.size() == 0);

        cpu_valid = 1'b1;
        cpu_addr  = a;
        cpu_write = wr;
        check("cpu_ready", cpu_ready, 1);
        @(posedge clock); #1;
        cpu_valid = 1'b0;
        lat   = 1;
        lat_g = -1;
        done  = 1'b0;
        pend  = snp_en;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            if (cpu_done) begin
                done = 1'b1;
                check("cpu_hit", cpu_hit, exp_hit);
                check("cpu_state", cpu_state, m_st[ri]);
                if (exp_hit) check("hit_latency", lat, 2);
                else         check("miss_latency", lat, lat_g);
                check("txn_left", plan.size(), 0);
                last_hit   = cpu_hit;
                last_state = cpu_state;
            end else if (bus_req) begin
                t = (plan.size() > 0) ? plan[0] : '0;
                seen.push_back(bus_cmd);
                check("bus_cmd", bus_cmd, t.cmd);
                check("bus_addr", bus_addr, t.addr);
                if (pend) begin
                    pend        = 1'b0;
                    snoop_valid = 1'b1;
                    snoop_cmd   = snp_cmd;
                    snoop_addr  = snp_addr;
                    #1;
                    model_snoop(snp_cmd, snp_addr, wb);
                    check("snoop_wb_bus", snoop_wb, wb);
                    if (plan.size() > 0) begin
                        t = plan[0];
                        if (t.cmd == C_INV && m_st[ri] == S_I) begin
                            t.cmd = C_WM;
                            plan[0] = t;
                        end else if (t.cmd == C_WB && m_st[ri] != S_M) begin
                            void'(plan.pop_front());
                        end
                    end
                    @(posedge clock); #1;
                    snoop_valid = 1'b0;
                    lat++;
                end else begin
                    bus_gnt    = 1'b1;
                    bus_shared = shared;
                    @(posedge clock); #1;
                    bus_gnt    = 1'b0;
                    bus_shared = 1'b0;
                    lat++;
                    lat_g = lat;
                    if (plan.size() > 0) begin
                        t = plan.pop_front();
                        if (t.cmd == C_WB) begin
                            m_st[ri] = S_I;
                        end else if (t.cmd == C_RM) begin
                            m_tag[ri] = rt;
                            m_st[ri]  = (EXCL && !shared) ? S_E : S_S;
                        end else begin
                            m_tag[ri] = rt;
                            m_st[ri]  = S_M;
                        end
                    end
                end
            end else begin
                @(posedge clock); #1;
                lat++;
            end
        end
        if (!done) check("done_timeout", 0, 1);
        @(posedge clock); #1;
    endtask

    initial begin
        logic        wb_got;
        logic [15:0] a, sa;
        logic [2:0]  ai;
        int          sel;

        model_reset();
        #1;
        check("rst_ready", cpu_ready, 0);
        check("rst_done", cpu_done, 0);
        check("rst_bus_req", bus_req, 0);
        check("rst_bus_cmd", bus_cmd, C_NONE);
        check("rst_snoop_wb", snoop_wb, 0);
        @(posedge clock); @(posedge clock); #3;
        reset_n = 1'b1;
        @(posedge clock); #1;
        check("rel_ready", cpu_ready, 1);

        // Read miss, then read hit
        run_access(16'h0012, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0);
        check("t1_hit", last_hit, 0);
        check("t1_state", last_state, S_S);
        check("t1_cmd", (seen.size() > 0) ? seen[0] : C_NONE, C_RM);
        run_access(16'h0012, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0);
        check("t1b_hit", last_hit, 1);
        check("t1b_nobus", seen.size(), 0);

        // Write upgrade, then snoop read supplies the dirty line
        run_access(16'h0012, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0);
        check("t2_cmd", (seen.size() > 0) ? seen[0] : C_NONE, C_INV);
        check("t2_state", last_state, S_M);
        snoop_idle(2'd1, 16'h0012, wb_got);
        check("t2_wb", wb_got, 1);
        run_access(16'h0012, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0);
        check("t2_after", last_state, S_S);

        // Dirty victim eviction
        run_access(16'h0012, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0);
        run_access(16'h0022, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0);
        check("t3_wb", (seen.size() > 1) ? seen[0] : C_NONE, C_WB);
        check("t3_rm", (seen.size() > 1) ? seen[1] : C_NONE, C_RM);
        check("t3_state", last_state, S_S);

        // Pending upgrade loses its copy to a snoop
        run_access(16'h0015, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0);
        run_access(16'h0015, 1'b1, 1'b1, 1'b1, 2'd2, 16'h0015);
        check("t4_inv", (seen.size() > 1) ? seen[0] : C_NONE, C_INV);
        check("t4_wm", (seen.size() > 1) ? seen[1] : C_NONE, C_WM);
        check("t4_state", last_state, S_M);

`ifdef COH_EXCLUSIVE_EN
        run_access(16'h0031, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
        check("t5_e", last_state, S_E);
        run_access(16'h0031, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0);
        check("t5_hit", last_hit, 1);
        check("t5_nobus", seen.size(), 0);
        check("t5_m", last_state, S_M);
`endif

        // Randomized traffic
        for (int n = 0; n < 250; n++) begin
            a  = {11'b0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
            ai = a[2:0];
            if ($urandom_range(0, 9) < 3) begin
                sa = {11'b0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
                snoop_idle(2'($urandom_range(1, 3)), sa, wb_got);
            end
            sel = $urandom_range(0, 2);
            if (sel == 0)      sa = a;
            else if (sel == 1) sa = {m_tag[ai], ai};
            else               sa = {11'b0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
            run_access(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 2'($urandom_range(1, 3)), sa);
        end

        // Reset while a bus request is outstanding
        cpu_valid = 1'b1;
        cpu_addr  = 16'h0044;
        cpu_write = 1'b0;
        @(posedge clock); #1;
        cpu_valid = 1'b0;
        for (int k = 0; k < 10 && !bus_req; k++) begin
            @(posedge clock); #1;
        end
        check("t6_req_before", bus_req, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_req_drop", bus_req, 0);
        check("t6_cmd_drop", bus_cmd, C_NONE);
        check("t6_ready_in_rst", cpu_ready, 0);
        check("t6_done_in_rst", cpu_done, 0);
        @(posedge clock); #3;
        reset_n = 1'b1;
        #1;
        check("t6_ready_after", cpu_ready, 1);
        model_reset();
        run_access(16'h0012, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0);
        check("t6_all_invalid", last_hit, 0);
        check("t6_single_txn", seen.size(), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
